qspi_flash_model: RTL and testbench

- Parametrised, synthesizable SPI/QSPI serial-flash responder for the FPGA system testbench and for on-FPGA loopback bring-up.
- Replaces the single-lane flash stub hung on qspi_cs/qspi_sck/qspi_dq.
- Oversamples the SPI pins on the system clock and serves single, dual and quad read commands from an internal byte array.
- The array is preloaded through a backdoor write port.

---
 rtl/qspi_model_pkg.sv | 32 +++
 rtl/qspi_pin_sync.sv | 46 ++++
 rtl/qspi_flash_model.sv | 203 ++++++++++++++++++++
 tb/tb_qspi_flash_model.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspi_model_pkg
// Purpose  : Shared definitions for the QSPI flash responder: supported read
//            opcodes, responder state encoding and data-lane mode encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package qspi_model_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_DREAD = 8'h3B;
    localparam logic [7:0] OP_QREAD = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } qspi_state_e;

    typedef enum logic [1:0] {
        MODE_X1 = 2'd0,
        MODE_X2 = 2'd1,
        MODE_X4 = 2'd2
    } lane_mode_e;

endpackage : qspi_model_pkg
`default_nettype wire

// File: rtl/qspi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : qspi_pin_sync
// Purpose  : Two-flop synchronisers for chip select and serial clock, plus a
//            third stage holding the previous synchronised sample so single
//            clk edge pulses can be derived.
// Ports    : clk, rst_n      - system clock, async active-low reset
//            cs_n_pin        - raw chip select pin
//            sck_pin         - raw serial clock pin
//            cs_fall/cs_rise - one-clk pulses on synchronised CS edges
//            sck_rise/sck_fall - one-clk pulses on synchronised SCK edges
// Revision : 1.0 - initial release
// ============================================================================
module qspi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n_pin,
    input  logic sck_pin,
    output logic cs_fall,
    output logic cs_rise,
    output logic sck_rise,
    output logic sck_fall
);

    // [0],[1] form the synchroniser, [2] is the previous synchronised value.
    logic [2:0] r_cs_pipe;
    logic [2:0] r_sck_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // CS idles deasserted so a held-high pin produces no edge pulse.
            r_cs_pipe  <= 3'b111;
            r_sck_pipe <= 3'b000;
        end else begin
            r_cs_pipe  <= {r_cs_pipe[1:0], cs_n_pin};
            r_sck_pipe <= {r_sck_pipe[1:0], sck_pin};
        end
    end

    assign cs_fall  =  r_cs_pipe[2]  & ~r_cs_pipe[1];
    assign cs_rise  = ~r_cs_pipe[2]  &  r_cs_pipe[1];
    assign sck_rise = ~r_sck_pipe[2] &  r_sck_pipe[1];
    assign sck_fall =  r_sck_pipe[2] & ~r_sck_pipe[1];

endmodule : qspi_pin_sync
`default_nettype wire

// File: rtl/qspi_flash_model.sv
`default_nettype none
// ============================================================================
// Module   : qspi_flash_model
// Purpose  : Oversampled SPI/QSPI serial-flash read responder (mode 0) with a
//            backdoor-loadable byte array. Serves 0x03, 0x0B, 0x3B and 0x6B.
// Ports    : clk, rst_n             - system clock, async active-low reset
//            spi_cs_n, spi_sck      - flash chip select and serial clock
//            spi_dq_i/o/oe [LANES]  - data lanes in/out and output enables
//            ld_en/ld_addr/ld_data  - backdoor byte write port
//            busy                   - transaction in progress
//            cmd_err                - one-clk pulse on unsupported opcode
// Revision : 1.0 - initial release
// ============================================================================
module qspi_flash_model
    import qspi_model_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DEPTH      = 4096,
    parameter int ADDR_BYTES = 3,
    parameter int DUMMY_CYC  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_cs_n,
    input  logic                     spi_sck,
    input  logic [LANES-1:0]         spi_dq_i,
    output logic [LANES-1:0]         spi_dq_o,
    output logic [LANES-1:0]         spi_dq_oe,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [7:0]               ld_data,
    output logic                     busy,
    output logic                     cmd_err
);

    localparam int         AW           = $clog2(DEPTH);
    // A single-lane build has no dq[1], so MISO falls back to lane 0 there.
    localparam int         MISO         = (LANES > 1) ? 1 : 0;
    localparam logic [7:0] C_CMD_LAST   = 8'd7;
    localparam logic [7:0] C_ADDR_LAST  = 8'(8 * ADDR_BYTES - 1);
    localparam logic [7:0] C_DUMMY_LAST = 8'(DUMMY_CYC - 1);

    logic [7:0] mem [DEPTH];

    logic        w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    qspi_state_e r_state, w_state_nxt;
    lane_mode_e  r_mode, w_op_mode;
    logic [7:0]  r_cnt;
    logic [31:0] r_shift, w_shift_in;
    logic [AW-1:0] r_addr;
    logic        r_dummy, w_op_dummy, w_op_ok;
    logic [2:0]  r_grp, w_grp_last;
    logic [7:0]  r_obyte, w_src, w_obyte_nxt;
    logic [3:0]  w_dq4, w_mask4;
    logic [LANES-1:0] r_dq_o;
    logic        r_cmd_err;
    logic        w_cmd_done, w_addr_done, w_dummy_done;
    logic        w_unused;

    qspi_pin_sync u_pin_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n_pin (spi_cs_n),
        .sck_pin  (spi_sck),
        .cs_fall  (w_cs_fall),
        .cs_rise  (w_cs_rise),
        .sck_rise (w_sck_rise),
        .sck_fall (w_sck_fall)
    );

    // Backdoor port; the array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign w_shift_in   = {r_shift[30:0], spi_dq_i[0]};
    assign w_cmd_done   = (r_state == ST_CMD)   && w_sck_rise && (r_cnt == C_CMD_LAST);
    assign w_addr_done  = (r_state == ST_ADDR)  && w_sck_rise && (r_cnt == C_ADDR_LAST);
    assign w_dummy_done = (r_state == ST_DUMMY) && w_sck_rise && (r_cnt == C_DUMMY_LAST);

    // Opcode decode on the bit completing the command byte.
    always_comb begin
        w_op_ok    = 1'b0;
        w_op_mode  = MODE_X1;
        w_op_dummy = 1'b0;
        case (w_shift_in[7:0])
            OP_READ:  w_op_ok = 1'b1;
            OP_FREAD: begin
                w_op_ok    = 1'b1;
                w_op_dummy = (DUMMY_CYC != 0);
            end
            OP_DREAD: begin
                w_op_ok    = (LANES >= 2);
                w_op_mode  = MODE_X2;
                w_op_dummy = (DUMMY_CYC != 0);
            end
            OP_QREAD: begin
                w_op_ok    = (LANES == 4);
                w_op_mode  = MODE_X4;
                w_op_dummy = (DUMMY_CYC != 0);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_cs_fall)    w_state_nxt = ST_CMD;
                ST_CMD:   if (w_cmd_done)   w_state_nxt = w_op_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (w_addr_done)  w_state_nxt = r_dummy ? ST_DUMMY : ST_DATA;
                ST_DUMMY: if (w_dummy_done) w_state_nxt = ST_DATA;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Data group selection: a new byte is read from the array on group 0,
    // later groups come from the remainder held in r_obyte.
    always_comb begin
        w_src       = (r_grp == 3'd0) ? mem[r_addr] : r_obyte;
        w_dq4       = 4'b0000;
        w_mask4     = 4'b0000;
        w_obyte_nxt = {w_src[6:0], 1'b0};
        w_grp_last  = 3'd7;
        case (r_mode)
            MODE_X2: begin
                w_dq4[1:0]  = w_src[7:6];
                w_mask4     = 4'b0011;
                w_obyte_nxt = {w_src[5:0], 2'b00};
                w_grp_last  = 3'd3;
            end
            MODE_X4: begin
                w_dq4       = w_src[7:4];
                w_mask4     = 4'b1111;
                w_obyte_nxt = {w_src[3:0], 4'b0000};
                w_grp_last  = 3'd1;
            end
            default: begin
                w_dq4[MISO]   = w_src[7];
                w_mask4[MISO] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_mode    <= MODE_X1;
            r_dummy   <= 1'b0;
            r_grp     <= '0;
            r_obyte   <= '0;
            r_dq_o    <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_done && !w_op_ok && !w_cs_rise;

            // The bit/cycle counter restarts at every phase change.
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_sck_rise)        r_cnt <= r_cnt + 8'd1;

            if (w_sck_rise && (r_state == ST_CMD || r_state == ST_ADDR))
                r_shift <= w_shift_in;

            if (w_cmd_done) begin
                r_mode  <= w_op_mode;
                r_dummy <= w_op_dummy;
            end

            // Upper address bits beyond the array size are dropped here.
            if (w_addr_done) r_addr <= w_shift_in[AW-1:0];

            if (r_state != ST_DATA) begin
                r_grp  <= '0;
                r_dq_o <= '0;
            end else if (w_sck_fall && !w_cs_rise) begin
                r_dq_o  <= w_dq4[LANES-1:0];
                r_obyte <= w_obyte_nxt;
                r_grp   <= (r_grp == w_grp_last) ? 3'd0 : r_grp + 3'd1;
                if (r_grp == 3'd0) r_addr <= r_addr + AW'(1);
            end
        end
    end

    assign spi_dq_o  = r_dq_o;
    assign spi_dq_oe = (r_state == ST_DATA && !w_cs_rise) ? w_mask4[LANES-1:0] : '0;
    assign busy      = (r_state != ST_IDLE);
    assign cmd_err   = r_cmd_err;

    assign w_unused  = ^{spi_dq_i, w_shift_in};

endmodule : qspi_flash_model
`default_nettype wire

// File: tb/tb_qspi_flash_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_flash_model
// Purpose  : Self-checking bench for qspi_flash_model (LANES=4, DEPTH=256).
//            A table of read transactions with expected bytes feeds a queue;
//            bytes assembled from the lanes are popped and compared. Extra
//            hand-written sequences cover bad opcode, CS abort and reset.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qspi_flash_model;
    import qspi_model_pkg::*;

    localparam int HALF = 6;   // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       sck = 1'b0;
    logic [3:0] dq_i = 4'h0;
    logic [3:0] dq_o, dq_oe;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;
    logic       busy, cmd_err;

    always #5 clk = ~clk;

    qspi_flash_model #(
        .LANES(4), .DEPTH(256), .ADDR_BYTES(3), .DUMMY_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_sck(sck),
        .spi_dq_i(dq_i), .spi_dq_o(dq_o), .spi_dq_oe(dq_oe),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .cmd_err(cmd_err)
    );

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          dummy;
        int          lanes;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_q [$];
    int         n_pass = 0;
    int         n_total = 0;
    int         err_cyc = 0;
    int         oe_cyc = 0;

    always @(negedge clk) begin
        if (cmd_err)       err_cyc++;
        if (dq_oe != 4'h0) oe_cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One mode-0 SCK period: MOSI set while low, lanes sampled at the rise.
    task automatic sck_cycle(input logic mosi, output logic [3:0] q, output logic [3:0] oe);
        dq_i = {3'b000, mosi};
        repeat (HALF) @(negedge clk);
        q  = dq_o;
        oe = dq_oe;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, inout logic oe_seen);
        logic [3:0] q, oe;
        for (int i = n - 1; i >= 0; i--) begin
            sck_cycle(bits[i], q, oe);
            if (oe != 4'h0) oe_seen = 1'b1;
        end
    endtask

    task automatic send_header(input logic [7:0] op, input logic [23:0] addr,
                               input int dummy, output logic oe_seen);
        oe_seen = 1'b0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits({24'h0, op}, 8, oe_seen);
        send_bits({8'h0, addr}, 24, oe_seen);
        if (dummy > 0) send_bits(32'h0, dummy, oe_seen);
    endtask

    task automatic end_cs();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_read(input vec_t v);
        logic       pre_oe, oe_bad;
        logic [3:0] q, oe, mask;
        logic [7:0] b, e;
        int         gpb;
        exp_q.push_back(v.exp0);
        exp_q.push_back(v.exp1);
        gpb  = 8 / v.lanes;
        mask = (v.lanes == 1) ? 4'b0010 : (v.lanes == 2) ? 4'b0011 : 4'b1111;
        oe_bad = 1'b0;
        send_header(v.op, v.addr, v.dummy, pre_oe);
        check("oe_before_data", {31'h0, pre_oe}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            b = 8'h00;
            for (int g = 0; g < gpb; g++) begin
                sck_cycle(1'b0, q, oe);
                if (oe !== mask) oe_bad = 1'b1;
                case (v.lanes)
                    1:       b = {b[6:0], q[1]};
                    2:       b = {b[5:0], q[1:0]};
                    default: b = {b[3:0], q[3:0]};
                endcase
            end
            e = exp_q.pop_front();
            check("read_byte", {24'h0, b}, {24'h0, e});
        end
        check("oe_in_data", {31'h0, oe_bad}, 32'h0);
        check("busy_in_xfer", {31'h0, busy}, 32'h1);
        end_cs();
        check("busy_after_cs", {31'h0, busy}, 32'h0);
        check("oe_after_cs", {28'h0, dq_oe}, 32'h0);
    endtask

    initial begin
        logic       dummy_seen;
        logic [3:0] q, oe, nib;
        int         e0, o0;

        vecs[0] = '{OP_READ,  24'h000010, 0, 1, 8'hA5, 8'h5A};
        vecs[1] = '{OP_FREAD, 24'h000010, 8, 1, 8'hA5, 8'h5A};
        vecs[2] = '{OP_QREAD, 24'h0000FF, 8, 4, 8'h3C, 8'hC3};
        vecs[3] = '{OP_DREAD, 24'h000010, 8, 2, 8'hA5, 8'h5A};

        repeat (3) @(negedge clk);
        check("rst_dq_o",   {28'h0, dq_o},    32'h0);
        check("rst_oe",     {28'h0, dq_oe},   32'h0);
        check("rst_busy",   {31'h0, busy},    32'h0);
        check("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        load(8'h10, 8'hA5);
        load(8'h11, 8'h5A);
        load(8'hFF, 8'h3C);
        load(8'h00, 8'hC3);

        for (int i = 0; i < 4; i++) do_read(vecs[i]);

        // Unsupported opcode: single-clk error pulse, never drives, stays busy.
        e0 = err_cyc; o0 = oe_cyc;
        dummy_seen = 1'b0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'h9F, 8, dummy_seen);
        send_bits(32'h0, 8, dummy_seen);
        check("bad_op_busy", {31'h0, busy}, 32'h1);
        end_cs();
        check("bad_op_err_cycles", err_cyc - e0, 32'h1);
        check("bad_op_oe_cycles",  oe_cyc - o0,  32'h0);
        check("bad_op_busy_after", {31'h0, busy}, 32'h0);

        // CS abort after four data bits of a single read.
        send_header(OP_READ, 24'h000010, 0, dummy_seen);
        nib = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sck_cycle(1'b0, q, oe);
            nib = {nib[2:0], q[1]};
        end
        check("abort_bits", {28'h0, nib}, 32'hA);
        repeat (HALF) @(negedge clk);
        check("abort_oe_before", {28'h0, dq_oe}, 32'h2);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_oe_3clk", {28'h0, dq_oe}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        do_read(vecs[0]);

        // Reset in the middle of the data phase.
        send_header(OP_READ, 24'h000010, 0, dummy_seen);
        for (int i = 0; i < 3; i++) sck_cycle(1'b0, q, oe);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_dq_o", {28'h0, dq_o},  32'h0);
        check("midrst_oe",   {28'h0, dq_oe}, 32'h0);
        check("midrst_busy", {31'h0, busy},  32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_read(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_qspi_flash_model
`default_nettype wire
